rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback path (MEM/WB register outputs) and a multi-cycle execution unit (MCU, e.g. iterative mul/div).
- Pipeline writeback always has priority. MCU results are buffered in a small FIFO and drained into idle writeback slots.
- Sits between the MEM/WB register and the register file write port.

Parameters:
- DEPTH, 2, MCU result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive lost cycles before a forced drain (used only with the optional feature)

Ports:
- clk  in  1  pipeline clock
- R  in  1  reset, synchronous, active-high
- rf_le_wb  in  1  writeback enable from MEM/WB register
- wb_mux_out  in  32  writeback data from MEM/WB register
- wb_rd  in  5  writeback destination from MEM/WB register
- mcu_valid  in  1  MCU result valid
- mcu_data  in  32  MCU result data
- mcu_rd  in  5  MCU result destination
- mcu_ready  out  1  buffer can accept an MCU result this cycle
- rf_we  out  1  register file write enable (registered)
- rf_wd  out  32  register file write data (registered)
- rf_wa  out  5  register file write address (registered)
- buf_count  out  log2(DEPTH)+1  current buffer occupancy
- pipe_stall  out  1  request to insert a writeback bubble (optional feature)

Behaviour:
- Reset (R=1 at posedge):
  - rf_we=0, rf_wd=0, rf_wa=0, buf_count=0, pipe_stall=0.
  - FIFO pointers are cleared and contents discarded, including any in-flight MCU result.
  - mcu_ready=0 while R=1.
- mcu_ready = !R && (buf_count < DEPTH). It is combinational from registered state only, with no combinational path from mcu_valid.
- Push: on posedge with mcu_valid && mcu_ready.
  - mcu_rd != 0: {mcu_rd, mcu_data} is written at the tail.
  - mcu_rd == 0 (%g0): the result is accepted and discarded, with no push.
- Grant is evaluated every posedge, in priority order:
  1. Pipeline: rf_le_wb=1 and wb_rd!=0. Then rf_we<=1, rf_wa<=wb_rd, rf_wd<=wb_mux_out.
  2. Buffer: the pipeline is not writing and buf_count>0. Then pop the head; rf_we<=1, rf_wa/rf_wd<=head entry.
  3. Otherwise rf_we<=0. rf_wa and rf_wd hold their previous values.
- A pipeline write to rd=0 counts as "not writing", so the buffer may drain in that slot.
- Latency:
  - Pipeline: write appears on the rf_* outputs 1 cycle after it is presented.
  - MCU: minimum 2 cycles (push at edge N, pop at edge N+1), with no bypass.
- Simultaneous push and pop in the same cycle is allowed. buf_count is unchanged, and FIFO order is preserved.
- Pointers wrap modulo DEPTH.
- Full: mcu_ready=0. The MCU must hold its result; an mcu_valid presented while full is ignored.
- Ordering: MCU results are written strictly in acceptance order.
- Write ordering between the pipeline and the MCU to the same rd is the issue logic's responsibility. This block does not detect or resolve such conflicts.

Optional Feature:
- Macro: RFARB_STARVE_EN.
- With RFARB_STARVE_EN defined:
  - starve_cnt increments each cycle that buf_count>0 and the pipeline wins the grant.
  - starve_cnt clears on any buffer pop, on buf_count==0, and on reset.
  - When starve_cnt reaches STARVE_LIMIT-1 and the pipeline wins again, pipe_stall<=1 for exactly one cycle.
  - Upstream then forces rf_le_mem=0, so the following cycle presents rf_le_wb=0 and the buffer head drains.
  - If upstream still presents rf_le_wb=1, the pipeline keeps priority, and pipe_stall re-asserts on the next lost cycle.
- Without the macro: pipe_stall is tied to 0, and no counter is instantiated.

Test Plan:
- Reset mid-operation: buffer holds 2 entries, assert R for 1 cycle -> buf_count=0, rf_we=0, mcu_ready=0 during R and 1 after; no stale writes afterwards.
- Pipeline only: rf_le_wb=1, wb_rd=5, wb_mux_out=0xDEADBEEF -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; repeat with wb_rd=0 -> rf_we=0.
- MCU into idle pipeline: mcu_valid=1, mcu_rd=9, mcu_data=0x12345678 with rf_le_wb=0 -> buf_count=1 after edge 1; rf_we=1, rf_wa=9 after edge 2; buf_count=0.
- Contention/full: rf_le_wb=1 continuously while the MCU sends rd=3, then rd=4 -> buf_count=2, mcu_ready=0, third result held. Drop rf_le_wb -> writes rd=3 then rd=4 in order, and mcu_ready returns to 1.
- Simultaneous push/pop: buf_count=1, rf_le_wb=0, mcu_valid=1 -> head written, new entry pushed, buf_count stays 1. MCU result with mcu_rd=0 -> discarded, buf_count unchanged.
- RFARB_STARVE_EN, STARVE_LIMIT=8: one buffered entry, rf_le_wb=1 for 8 cycles -> pipe_stall pulses high for 1 cycle; bench drops rf_le_wb next cycle -> buffered entry written, counter clears.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority and MCU results wait in a FIFO.
// Optional starvation guard (pipe_stall) is enabled by defining RFARB_STARVE_EN.
module rf_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     rf_le_wb,
  input  logic [31:0]              wb_mux_out,
  input  logic [4:0]               wb_rd,
  input  logic                     mcu_valid,
  input  logic [31:0]              mcu_data,
  input  logic [4:0]               mcu_rd,
  output logic                     mcu_ready,
  output logic                     rf_we,
  output logic [31:0]              rf_wd,
  output logic [4:0]               rf_wa,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     pipe_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic          accept, push, pop, pipe_win;
  logic          rf_we_q;
  logic [4:0]    rf_wa_q;
  logic [31:0]   rf_wd_q;

  // Ready depends only on reset and stored occupancy, never on mcu_valid.
  assign mcu_ready = !R && (count_q < CW'(DEPTH));
  assign accept    = mcu_valid && mcu_ready;
  // Results for %g0 are consumed but never stored.
  assign push      = accept && (mcu_rd != 5'd0);
  assign pipe_win  = rf_le_wb && (wb_rd != 5'd0);
  assign pop       = !pipe_win && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!R && push) begin
      fifo_rd_q[wr_ptr_q]   <= mcu_rd;
      fifo_data_q[wr_ptr_q] <= mcu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= 5'd0;
      rf_wd_q <= 32'd0;
    end else if (pipe_win) begin
      rf_we_q <= 1'b1;
      rf_wa_q <= wb_rd;
      rf_wd_q <= wb_mux_out;
    end else if (pop) begin
      rf_we_q <= 1'b1;
      rf_wa_q <= fifo_rd_q[rd_ptr_q];
      rf_wd_q <= fifo_data_q[rd_ptr_q];
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign buf_count = count_q;

`ifdef RFARB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          pipe_stall_q, pipe_stall_d;

  // Counter saturates at the limit so every further lost cycle re-raises the stall.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    pipe_stall_d = 1'b0;
    if (pop || (count_q == '0)) begin
      starve_cnt_d = '0;
    end else if (pipe_win) begin
      if (starve_cnt_q >= SW'(STARVE_LIMIT - 1)) begin
        pipe_stall_d = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  assign pipe_stall = pipe_stall_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign pipe_stall          = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        R;
  logic        rf_le_wb;
  logic [31:0] wb_mux_out;
  logic [4:0]  wb_rd;
  logic        mcu_valid;
  logic [31:0] mcu_data;
  logic [4:0]  mcu_rd;
  logic        mcu_ready;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic [4:0]  rf_wa;
  logic [1:0]  buf_count;
  logic        pipe_stall;

  int checks = 0;
  int errors = 0;

`ifdef RFARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .R          (R),
    .rf_le_wb   (rf_le_wb),
    .wb_mux_out (wb_mux_out),
    .wb_rd      (wb_rd),
    .mcu_valid  (mcu_valid),
    .mcu_data   (mcu_data),
    .mcu_rd     (mcu_rd),
    .mcu_ready  (mcu_ready),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .rf_wa      (rf_wa),
    .buf_count  (buf_count),
    .pipe_stall (pipe_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        le;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    rf_le_wb   = le;
    wb_rd      = wrd;
    wb_mux_out = wdat;
    mcu_valid  = mv;
    mcu_rd     = mrd;
    mcu_data   = mdat;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [1:0] cnt, input logic rdy);
    chk({tag, ".rf_we"},     {31'd0, rf_we},     {31'd0, we});
    chk({tag, ".rf_wa"},     {27'd0, rf_wa},     {27'd0, wa});
    chk({tag, ".rf_wd"},     rf_wd,              wd);
    chk({tag, ".buf_count"}, {30'd0, buf_count}, {30'd0, cnt});
    chk({tag, ".mcu_ready"}, {31'd0, mcu_ready}, {31'd0, rdy});
  endtask

  initial begin
    //             le wrd    wdat          mv mrd    mdat          we wa     wd            cnt   rdy
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,
                 1'b1, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0,  32'h0,
                 1'b0, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h12345678,
                 1'b0, 5'd5,  32'hDEADBEEF, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                 1'b1, 5'd9,  32'h12345678, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                 1'b0, 5'd9,  32'h12345678, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hA0A0A0A0,
                 1'b0, 5'd9,  32'h12345678, 2'd1, 1'b1};
    // Simultaneous push and pop: head written, occupancy unchanged.
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'hB0B0B0B0,
                 1'b1, 5'd7,  32'hA0A0A0A0, 2'd1, 1'b1};
    // MCU result to %g0 is dropped while the pipeline holds the port.
    vecs[7]  = '{1'b1, 5'd2,  32'h22222222, 1'b1, 5'd0,  32'hCCCCCCCC,
                 1'b1, 5'd2,  32'h22222222, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 5'd2,  32'h0,        1'b0, 5'd0,  32'h0,
                 1'b1, 5'd8,  32'hB0B0B0B0, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd10, 32'h0A0A0A0A,
                 1'b0, 5'd8,  32'hB0B0B0B0, 2'd1, 1'b1};
    // Pipeline write to rd=0 leaves the slot free for the buffer.
    vecs[10] = '{1'b1, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                 1'b1, 5'd10, 32'h0A0A0A0A, 2'd0, 1'b1};

    R = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk_out("reset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b0);
    chk("reset.pipe_stall", {31'd0, pipe_stall}, 32'd0);
    R = 1'b0;
    #1;
    chk("reset.ready_after", {31'd0, mcu_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].le, vecs[i].wrd, vecs[i].wdat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cnt,
              vecs[i].rdy);
      chk($sformatf("vec%0d.pipe_stall", i), {31'd0, pipe_stall}, 32'd0);
    end

    // Contention until full, then drain in acceptance order.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h33);
    tick();
    chk_out("full.a", 1'b1, 5'd1, 32'h100, 2'd1, 1'b1);
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd4, 32'h44);
    tick();
    chk_out("full.b", 1'b1, 5'd1, 32'h101, 2'd2, 1'b0);
    drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd5, 32'h55);
    tick();
    chk_out("full.held", 1'b1, 5'd1, 32'h102, 2'd2, 1'b0);
    drive(1'b0, 5'd1, 32'h0, 1'b1, 5'd5, 32'h55);
    tick();
    chk_out("drain.rd3", 1'b1, 5'd3, 32'h33, 2'd1, 1'b1);
    tick();
    chk_out("drain.rd4", 1'b1, 5'd4, 32'h44, 2'd1, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("drain.rd5", 1'b1, 5'd5, 32'h55, 2'd0, 1'b1);
    tick();
    chk_out("drain.idle", 1'b0, 5'd5, 32'h55, 2'd0, 1'b1);

    // Reset with two buffered entries and an MCU result in flight.
    drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd20, 32'h2000);
    tick();
    drive(1'b1, 5'd6, 32'h601, 1'b1, 5'd21, 32'h2100);
    tick();
    chk_out("prerst", 1'b1, 5'd6, 32'h601, 2'd2, 1'b0);
    drive(1'b1, 5'd6, 32'h602, 1'b1, 5'd22, 32'h2200);
    R = 1'b1;
    #1;
    chk("midrst.ready_during", {31'd0, mcu_ready}, 32'd0);
    tick();
    chk_out("midrst", 1'b0, 5'd0, 32'h0, 2'd0, 1'b0);
    R = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("midrst.ready_after", {31'd0, mcu_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("postrst%0d", i), 1'b0, 5'd0, 32'h0, 2'd0, 1'b1);
    end

    // Starvation: one buffered entry while the pipeline keeps winning.
    drive(1'b1, 5'd13, 32'h1300, 1'b1, 5'd14, 32'h1400);
    tick();
    chk_out("starve.push", 1'b1, 5'd13, 32'h1300, 2'd1, 1'b1);
    drive(1'b1, 5'd13, 32'h1300, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_out($sformatf("starve%0d", i), 1'b1, 5'd13, 32'h1300, 2'd1, 1'b1);
      chk($sformatf("starve%0d.pipe_stall", i), {31'd0, pipe_stall},
          {31'd0, StarveOn && (i == 8)});
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("starve.drain", 1'b1, 5'd14, 32'h1400, 2'd0, 1'b1);
    chk("starve.drain.pipe_stall", {31'd0, pipe_stall}, 32'd0);

    // Counter must have cleared: one more lost cycle does not stall.
    drive(1'b1, 5'd15, 32'h1500, 1'b1, 5'd16, 32'h1600);
    tick();
    drive(1'b1, 5'd15, 32'h1501, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("starve.again", 1'b1, 5'd15, 32'h1501, 2'd1, 1'b1);
    chk("starve.again.pipe_stall", {31'd0, pipe_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
